uart_pixel_parser: RTL

UART_PIXEL_PARSER -- requirements
Module: uart_pixel_parser

---
 rtl/uart_pixel_parser.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/uart_pixel_parser.sv
// uart_pixel_parser: turns framed UART bytes into pixel writes.
// A frame is SYNC(0xA5), ADDR, R, G, B, W, CHK where CHK = ADDR^R^G^B^W.
// A good frame writes one pixel word and answers 0x06. A bad checksum
// answers 0x15. An inter-byte gap that is too long drops the frame silently.
// Ports:
//   clockIN      : clock, rising edge
//   ResetIN      : asynchronous active-low reset
//   rxDataIN     : received byte
//   rxReadyIN    : one-cycle strobe marking rxDataIN valid
//   txReadyIN    : transmitter can accept a byte
//   txDataOUT    : response byte, held until the next response
//   txLoadOUT    : one-cycle load strobe for txDataOUT
//   pixAddrOUT   : pixel index of the last good frame
//   pixDataOUT   : pixel word {G,R,B,W} of the last good frame
//   pixWriteOUT  : one-cycle pixel write strobe
//   busyOUT      : high whenever the parser is not idle
//   errCountOUT  : saturating count of checksum failures plus timeouts
module uart_pixel_parser #(
   parameter int unsigned CLOCK_FREQUENCY = 50_000_000,
   parameter int unsigned TIMEOUT_CYCLES  = 50_000
) (
   input  logic        clockIN,
   input  logic        ResetIN,
   input  logic [7:0]  rxDataIN,
   input  logic        rxReadyIN,
   input  logic        txReadyIN,
   output logic [7:0]  txDataOUT,
   output logic        txLoadOUT,
   output logic [7:0]  pixAddrOUT,
   output logic [31:0] pixDataOUT,
   output logic        pixWriteOUT,
   output logic        busyOUT,
   output logic [7:0]  errCountOUT
);

   localparam int unsigned TW   = $clog2(TIMEOUT_CYCLES) + 1;
   localparam logic [7:0]  SYNC = 8'hA5;
   localparam logic [7:0]  ACK  = 8'h06;
   localparam logic [7:0]  NAK  = 8'h15;

   // Reject parameter values that make the timeout or clock meaningless.
   if (TIMEOUT_CYCLES < 2 || CLOCK_FREQUENCY == 0) begin : gBadParam
      $error("uart_pixel_parser: TIMEOUT_CYCLES must be >= 2 and CLOCK_FREQUENCY > 0");
   end

   typedef enum logic [2:0] {
      S_IDLE, S_ADDR, S_RED, S_GRN, S_BLU, S_WHT, S_CHK, S_RESP
   } state_t;

   state_t         state, stateNext;
   logic [TW-1:0]  toCount;
   logic [7:0]     addrReg, redReg, grnReg, bluReg, whtReg, respReg;
   logic [7:0]     chkCalc;
   logic           inFrame, timeoutHit;
   logic           goodC, badC, expireC, errIncC, txLoadC, countClearC;

   assign inFrame    = (state != S_IDLE) && (state != S_RESP);
   assign timeoutHit = (toCount == TW'(TIMEOUT_CYCLES - 1));
   assign chkCalc    = addrReg ^ redReg ^ grnReg ^ bluReg ^ whtReg;

   // State register.
   always_ff @(posedge clockIN or negedge ResetIN) begin
      if (!ResetIN) state <= S_IDLE;
      else          state <= stateNext;
   end

   // Next state: a byte strobe always wins over timeout expiry.
   always_comb begin
      stateNext = state;
      case (state)
         S_IDLE: if (rxReadyIN && rxDataIN == SYNC) stateNext = S_ADDR;
         S_ADDR: if (rxReadyIN) stateNext = S_RED; else if (timeoutHit) stateNext = S_IDLE;
         S_RED:  if (rxReadyIN) stateNext = S_GRN; else if (timeoutHit) stateNext = S_IDLE;
         S_GRN:  if (rxReadyIN) stateNext = S_BLU; else if (timeoutHit) stateNext = S_IDLE;
         S_BLU:  if (rxReadyIN) stateNext = S_WHT; else if (timeoutHit) stateNext = S_IDLE;
         S_WHT:  if (rxReadyIN) stateNext = S_CHK; else if (timeoutHit) stateNext = S_IDLE;
         S_CHK:  if (rxReadyIN) stateNext = S_RESP; else if (timeoutHit) stateNext = S_IDLE;
         S_RESP: if (txReadyIN) stateNext = S_IDLE;
         default: stateNext = S_IDLE;
      endcase
   end

   // Output decode; the results are registered below.
   always_comb begin
      goodC       = 1'b0;
      badC        = 1'b0;
      expireC     = 1'b0;
      txLoadC     = 1'b0;
      countClearC = 1'b1;
      if (state == S_CHK && rxReadyIN) begin
         goodC = (rxDataIN == chkCalc);
         badC  = (rxDataIN != chkCalc);
      end
      if (inFrame) begin
         expireC     = !rxReadyIN && timeoutHit;
         countClearC = rxReadyIN;
      end
      if (state == S_RESP) txLoadC = txReadyIN;
      errIncC = badC || expireC;
   end

   // Payload capture, registered outputs and the gap counter.
   always_ff @(posedge clockIN or negedge ResetIN) begin
      if (!ResetIN) begin
         toCount     <= '0;
         addrReg     <= '0;
         redReg      <= '0;
         grnReg      <= '0;
         bluReg      <= '0;
         whtReg      <= '0;
         respReg     <= '0;
         txDataOUT   <= '0;
         txLoadOUT   <= 1'b0;
         pixAddrOUT  <= '0;
         pixDataOUT  <= '0;
         pixWriteOUT <= 1'b0;
         busyOUT     <= 1'b0;
         errCountOUT <= '0;
      end else begin
         pixWriteOUT <= goodC;
         txLoadOUT   <= txLoadC;
         busyOUT     <= (stateNext != S_IDLE);
         toCount     <= countClearC ? '0 : toCount + TW'(1);
         if (rxReadyIN) begin
            case (state)
               S_ADDR:  addrReg <= rxDataIN;
               S_RED:   redReg  <= rxDataIN;
               S_GRN:   grnReg  <= rxDataIN;
               S_BLU:   bluReg  <= rxDataIN;
               S_WHT:   whtReg  <= rxDataIN;
               default: ;
            endcase
         end
         if (goodC) begin
            pixAddrOUT <= addrReg;
            pixDataOUT <= {grnReg, redReg, bluReg, whtReg};
            respReg    <= ACK;
         end
         if (badC) respReg <= NAK;
         if (txLoadC) txDataOUT <= respReg;
         if (errIncC && errCountOUT != 8'hFF) errCountOUT <= errCountOUT + 8'd1;
      end
   end

endmodule
